cycle_terminator: RTL and testbench

- Parametrised bus-cycle termination engine for the 68030 side of the accelerator.
- Generalises the fixed per-region DSACK/BERR logic into NWIN decoded windows. Each window has its own wait-state count and port size.
- Adds an external-ack path with a programmable bus-error timeout.
- Sits between the address decoder and the CPU DSACK/BERR pins; fully synchronous to CPUCLK.

---
 rtl/cycle_terminator_if.sv | 30 +++
 rtl/cycle_terminator.sv | 171 +++++++++++++++++
 tb/tb_cycle_terminator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cycle_terminator_if.sv
// Bus-side signal bundle for cycle_terminator: decoder/CPU inputs and DSACK/BERR/AVEC/BUSY outputs.
// The slave modport is the terminator's view; master is the CPU/decoder side.
interface cycle_terminator_if #(
  parameter int unsigned NWIN   = 4,
  parameter int unsigned WAIT_W = 4
) ();
  logic                     AS;
  logic [2:0]               FC;
  logic [31:0]              A;
  logic [NWIN-1:0]          WIN_HIT;
  logic [NWIN*WAIT_W-1:0]   WIN_WAIT;
  logic [NWIN*2-1:0]        WIN_SIZE;
  logic                     EXT_ACK;
  logic [1:0]               EXT_SIZE;
  logic                     TO_EN;
  logic [1:0]               DSACK;
  logic                     BERR;
  logic                     AVEC;
  logic                     BUSY;

  modport slave (
    input  AS, FC, A, WIN_HIT, WIN_WAIT, WIN_SIZE, EXT_ACK, EXT_SIZE, TO_EN,
    output DSACK, BERR, AVEC, BUSY
  );

  modport master (
    output AS, FC, A, WIN_HIT, WIN_WAIT, WIN_SIZE, EXT_ACK, EXT_SIZE, TO_EN,
    input  DSACK, BERR, AVEC, BUSY
  );
endinterface

// File: rtl/cycle_terminator.sv
// 68030 bus-cycle termination engine: NWIN decoded windows with per-window wait states and
// port size, plus an external-ack path guarded by a bus-error timeout.
// Optional macro CYCLE_TERM_AVEC_EN: decode IACK autovector cycles and terminate them with AVEC.
module cycle_terminator #(
  parameter int unsigned NWIN   = 4,
  parameter int unsigned WAIT_W = 4,
  parameter int unsigned TO_W   = 7
) (
  input logic               CPUCLK,
  input logic               RST,
  cycle_terminator_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_EXT  = 3'd2,
    S_ACK  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                iack_q, iack_d;
  logic [1:0]          dsack_q, dsack_d;
  logic                berr_q, berr_d;
  logic                avec_q, avec_d;
  logic                busy_q, busy_d;

  logic                hit_found_c;
  logic [1:0]          hit_size_c;
  logic [WAIT_W-1:0]   hit_wait_c;
  logic                is_iack_c;

  // Priority window select: scanning downward leaves the lowest eligible index in place.
  always_comb begin
    hit_found_c = 1'b0;
    hit_size_c  = 2'b00;
    hit_wait_c  = '0;
    for (int i = int'(NWIN) - 1; i >= 0; i--) begin
      if (bus.WIN_HIT[i] && (bus.WIN_SIZE[2*i +: 2] != 2'b00)) begin
        hit_found_c = 1'b1;
        hit_size_c  = bus.WIN_SIZE[2*i +: 2];
        hit_wait_c  = bus.WIN_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
  end

`ifdef CYCLE_TERM_AVEC_EN
  logic unused_addr_c;

  // IACK autovector decode: CPU space, interrupt-ack type, levels 2 or 4.
  always_comb begin
    is_iack_c = (bus.FC == 3'b111) && (bus.A[19:16] == 4'hF) &&
                ((bus.A[3:1] == 3'd2) || (bus.A[3:1] == 3'd4));
  end
  assign unused_addr_c = ^{bus.A[31:20], bus.A[15:4], bus.A[0]};
`else
  logic unused_addr_c;

  // Autovector support compiled out: no cycle is ever treated as IACK.
  always_comb begin
    is_iack_c = 1'b0;
  end
  assign unused_addr_c = ^{bus.FC, bus.A};
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    wait_d  = wait_q;
    to_d    = to_q;
    iack_d  = iack_q;
    dsack_d = 2'b11;
    berr_d  = 1'b1;
    avec_d  = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!bus.AS) begin
          iack_d = is_iack_c;
          if (is_iack_c || !hit_found_c) begin
            state_d = S_EXT;
            to_d    = '0;
          end else begin
            size_d  = hit_size_c;
            wait_d  = hit_wait_c;
            state_d = (hit_wait_c == '0) ? S_ACK : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_W'(1)) begin
          state_d = S_ACK;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_EXT: begin
        // An acknowledge on the same edge as the timeout MSB still terminates normally.
        if (!bus.EXT_ACK && (iack_q || (bus.EXT_SIZE != 2'b00))) begin
          size_d  = bus.EXT_SIZE;
          state_d = S_ACK;
        end else if (bus.TO_EN) begin
          to_d = to_q + TO_W'(1);
          if (to_d[TO_W-1]) begin
            state_d = S_ERR;
          end
        end
      end
      S_ACK: begin
        if (iack_q) begin
          avec_d = 1'b0;
        end else begin
          // Size code 01/10/11 maps to DSACK 10/01/00, i.e. its bitwise inverse.
          dsack_d = ~size_q;
        end
      end
      S_ERR: begin
        berr_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // AS released ends any tracked cycle, including aborted WAIT/EXT, with outputs idle.
    if ((state_q != S_IDLE) && bus.AS) begin
      state_d = S_IDLE;
      dsack_d = 2'b11;
      berr_d  = 1'b1;
      avec_d  = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CPUCLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      size_q  <= 2'b00;
      wait_q  <= '0;
      to_q    <= '0;
      iack_q  <= 1'b0;
      dsack_q <= 2'b11;
      berr_q  <= 1'b1;
      avec_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
      iack_q  <= iack_d;
      dsack_q <= dsack_d;
      berr_q  <= berr_d;
      avec_q  <= avec_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.DSACK = dsack_q;
  assign bus.BERR  = berr_q;
  assign bus.AVEC  = avec_q;
  assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_cycle_terminator.sv
// Directed bench for cycle_terminator: expected outputs queued per stimulus step, compared after each edge.
module tb_cycle_terminator;

  localparam int unsigned NWIN   = 4;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned TO_W   = 7;

  typedef struct packed {
    logic [1:0] dsack;
    logic       berr;
    logic       avec;
    logic       busy;
  } exp_t;

  logic  CPUCLK;
  logic  RST;
  int    checks;
  int    errors;
  exp_t  exp_q[$];
  string tag_q[$];

  cycle_terminator_if #(.NWIN(NWIN), .WAIT_W(WAIT_W)) bus ();

  cycle_terminator #(.NWIN(NWIN), .WAIT_W(WAIT_W), .TO_W(TO_W)) dut (
    .CPUCLK (CPUCLK),
    .RST    (RST),
    .bus    (bus.slave)
  );

  initial CPUCLK = 1'b0;
  always #5 CPUCLK = ~CPUCLK;

  // Queue the expectation for the coming edge, advance one edge, then pop and compare.
  task automatic tick(input string tag, input logic [1:0] ds, input logic be,
                      input logic av, input logic bu);
    exp_t e;
    exp_t obs;
    string t;
    e.dsack = ds;
    e.berr  = be;
    e.avec  = av;
    e.busy  = bu;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CPUCLK);
    #1;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = '{dsack: bus.DSACK, berr: bus.BERR, avec: bus.AVEC, busy: bus.BUSY};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed dsack=%b berr=%b avec=%b busy=%b expected dsack=%b berr=%b avec=%b busy=%b",
             t, obs.dsack, obs.berr, obs.avec, obs.busy, e.dsack, e.berr, e.avec, e.busy);
    end
  endtask

  task automatic idle_tick(input string tag);
    tick(tag, 2'b11, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic busy_tick(input string tag);
    tick(tag, 2'b11, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST          = 1'b0;
    bus.AS       = 1'b1;
    bus.FC       = 3'b000;
    bus.A        = 32'h0;
    bus.WIN_HIT  = '0;
    bus.WIN_WAIT = '0;
    bus.WIN_SIZE = '0;
    bus.EXT_ACK  = 1'b1;
    bus.EXT_SIZE = 2'b00;
    bus.TO_EN    = 1'b0;

    // Reset state
    idle_tick("reset");
    RST = 1'b1;
    idle_tick("idle_after_reset");

    // Window 0, zero wait states, 32-bit port
    bus.WIN_HIT  = 4'b0001;
    bus.WIN_SIZE = 8'b00_00_00_11;
    bus.WIN_WAIT = 16'h0000;
    bus.AS = 1'b0;
    busy_tick("w0_start");
    tick("w0_dsack", 2'b00, 1'b1, 1'b1, 1'b1);
    bus.WIN_HIT  = 4'b0000;
    bus.WIN_SIZE = 8'b00_00_00_01;
    tick("w0_hold_cfg_change", 2'b00, 1'b1, 1'b1, 1'b1);
    bus.AS = 1'b1;
    idle_tick("w0_release");
    idle_tick("w0_idle");

    // Priority and wait states: window1 (W=3, 16-bit) beats window2 (W=0, 8-bit)
    bus.WIN_HIT  = 4'b0110;
    bus.WIN_SIZE = 8'b00_01_10_00;
    bus.WIN_WAIT = 16'h0030;
    bus.AS = 1'b0;
    busy_tick("w1_start");
    busy_tick("w1_wait1");
    busy_tick("w1_wait2");
    busy_tick("w1_wait3");
    tick("w1_dsack_edge4", 2'b01, 1'b1, 1'b1, 1'b1);
    bus.AS = 1'b1;
    idle_tick("w1_release");

    // Disabled window (size 00) is skipped in favour of the next eligible one
    bus.WIN_HIT  = 4'b0011;
    bus.WIN_SIZE = 8'b00_00_01_00;
    bus.WIN_WAIT = 16'h0000;
    bus.AS = 1'b0;
    busy_tick("skip_start");
    tick("skip_dsack8", 2'b10, 1'b1, 1'b1, 1'b1);
    bus.AS = 1'b1;
    idle_tick("skip_release");

    // Timeout: 64 counting edges then ERR, BERR one edge later
    bus.WIN_HIT = 4'b0000;
    bus.TO_EN   = 1'b1;
    bus.AS = 1'b0;
    busy_tick("to_start");
    for (int k = 1; k <= 64; k++) busy_tick($sformatf("to_count%0d", k));
    tick("to_berr", 2'b11, 1'b0, 1'b1, 1'b1);
    tick("to_berr_hold", 2'b11, 1'b0, 1'b1, 1'b1);
    bus.AS = 1'b1;
    idle_tick("to_release");

    // External ack at cycle 5, 8-bit
    bus.EXT_SIZE = 2'b01;
    bus.AS = 1'b0;
    busy_tick("ext_start");
    for (int k = 1; k <= 4; k++) busy_tick($sformatf("ext_wait%0d", k));
    bus.EXT_ACK = 1'b0;
    busy_tick("ext_ack_sampled");
    tick("ext_dsack8", 2'b10, 1'b1, 1'b1, 1'b1);
    bus.EXT_ACK = 1'b1;
    bus.AS = 1'b1;
    idle_tick("ext_release");

    // Ack coincident with timeout MSB: ack wins, 16-bit
    bus.EXT_SIZE = 2'b10;
    bus.AS = 1'b0;
    busy_tick("race_start");
    for (int k = 1; k <= 63; k++) busy_tick($sformatf("race_count%0d", k));
    bus.EXT_ACK = 1'b0;
    busy_tick("race_edge64");
    tick("race_dsack_not_berr", 2'b01, 1'b1, 1'b1, 1'b1);
    bus.EXT_ACK = 1'b1;
    bus.AS = 1'b1;
    idle_tick("race_release");

    // Abort during wait states: W=5, AS released after 2 cycles
    bus.TO_EN    = 1'b0;
    bus.WIN_HIT  = 4'b0001;
    bus.WIN_SIZE = 8'b00_00_00_11;
    bus.WIN_WAIT = 16'h0005;
    bus.AS = 1'b0;
    busy_tick("abort_start");
    busy_tick("abort_wait1");
    busy_tick("abort_wait2");
    bus.AS = 1'b1;
    for (int k = 0; k < 6; k++) idle_tick($sformatf("abort_no_dsack%0d", k));

    // Reset during ACK
    bus.WIN_WAIT = 16'h0000;
    bus.AS = 1'b0;
    busy_tick("rst_start");
    tick("rst_dsack", 2'b00, 1'b1, 1'b1, 1'b1);
    RST = 1'b0;
    idle_tick("rst_mid_ack");
    RST = 1'b1;
    bus.AS = 1'b1;
    idle_tick("rst_idle");

    // IACK autovector cycle with a window also hitting
    bus.FC       = 3'b111;
    bus.A        = 32'h000F_0008;
    bus.EXT_ACK  = 1'b0;
    bus.EXT_SIZE = 2'b00;
    bus.AS = 1'b0;
    busy_tick("iack_start");
`ifdef CYCLE_TERM_AVEC_EN
    busy_tick("iack_ack_sampled");
    tick("iack_avec", 2'b11, 1'b1, 1'b0, 1'b1);
    tick("iack_avec_hold", 2'b11, 1'b1, 1'b0, 1'b1);
`else
    tick("iack_as_window", 2'b00, 1'b1, 1'b1, 1'b1);
    tick("iack_no_avec", 2'b00, 1'b1, 1'b1, 1'b1);
    tick("iack_no_avec_hold", 2'b00, 1'b1, 1'b1, 1'b1);
`endif
    bus.AS      = 1'b1;
    bus.EXT_ACK = 1'b1;
    idle_tick("iack_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
